data_mem_responder: RTL and testbench

Data-memory responder on the load/store path: the slave end of the control unit's memory request interface (address, read enable, write enable, write data), returning load data. It holds a word-organised RAM and services one byte, halfword or word access at a time, with a configurable number of wait states. On reads it performs lane extraction and sign/zero extension. It reports misaligned, out-of-range and conflicting requests as errors instead of performing them.

---
 rtl/data_mem_responder_if.sv | 27 ++
 rtl/data_mem_responder.sv | 161 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the control unit (master) and the
// data-memory responder (slave).
//   req_addr/req_rd/req_wr/req_size/req_unsigned/req_wdata : request, master -> slave
//   req_ready                                              : slave can accept this cycle
//   resp_valid/resp_rdata/resp_err                         : one-cycle response pulse
interface data_mem_responder_if;
    logic [31:0] req_addr;
    logic        req_rd;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_addr, req_rd, req_wr, req_size, req_unsigned, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_addr, req_rd, req_wr, req_size, req_unsigned, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: word-organised RAM serving one byte/halfword/word
// load or store at a time, with WAIT_STATES extra cycles of latency. Loads are
// lane-extracted and sign/zero extended; misaligned, out-of-range, illegal-size
// and read+write requests return resp_err without touching memory.
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset (RAM contents are kept)
//   bus_io : slave side of data_mem_responder_if
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input logic                 clk,
    input logic                 rst,
    data_mem_responder_if.slave bus_io
);

    localparam int unsigned IdxW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [33:0] ByteLimit = 34'(DEPTH_WORDS) << 2;
    localparam logic [2:0]  CntInit   = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] ram_q [DEPTH_WORDS];

    // Request fields latched at acceptance
    logic [31:0] data_q;
    logic [1:0]  lane_q, size_q;
    logic        uns_q, err_q, rd_q;

    logic        resp_valid_q, resp_err_q;
    logic [31:0] resp_rdata_q;

    logic            accept, req_err, wr_en;
    logic [IdxW-1:0] idx;
    logic [3:0]      be;
    logic [31:0]     wdata_rep, load_shift, load_ext;

    assign idx    = bus_io.req_addr[IdxW+1:2];
    assign accept = !rst && (state_q == StIdle) && (bus_io.req_rd || bus_io.req_wr);

    // Range check is done on 34 bits so addresses near 2^32 cannot wrap
    assign req_err = (bus_io.req_rd && bus_io.req_wr)
                   || (bus_io.req_size == 2'b11)
                   || (bus_io.req_size == 2'b01 && bus_io.req_addr[0])
                   || (bus_io.req_size == 2'b10 && bus_io.req_addr[1:0] != 2'b00)
                   || ({2'b00, bus_io.req_addr} >= ByteLimit);

    assign wr_en = accept && bus_io.req_wr && !req_err;

    always_comb begin
        be        = 4'b0000;
        wdata_rep = bus_io.req_wdata;
        case (bus_io.req_size)
            2'b00: begin
                be        = 4'b0001 << bus_io.req_addr[1:0];
                wdata_rep = {4{bus_io.req_wdata[7:0]}};
            end
            2'b01: begin
                be        = bus_io.req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{bus_io.req_wdata[15:0]}};
            end
            2'b10: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // RAM is deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) ram_q[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (WAIT_STATES > 0) begin
                        state_d = StWait;
                        cnt_d   = CntInit;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 3'd0) state_d = StResp;
                else               cnt_d   = cnt_q - 3'd1;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            lane_q <= 2'd0;
            size_q <= 2'd0;
            uns_q  <= 1'b0;
            err_q  <= 1'b0;
            rd_q   <= 1'b0;
        end else if (accept) begin
            data_q <= (bus_io.req_rd && !req_err) ? ram_q[idx] : '0;
            lane_q <= bus_io.req_addr[1:0];
            size_q <= bus_io.req_size;
            uns_q  <= bus_io.req_unsigned;
            err_q  <= req_err;
            rd_q   <= bus_io.req_rd;
        end
    end

    // Halfwords are aligned, so lane_q[0] is 0 and the shift is 0 or 16
    assign load_shift = data_q >> {lane_q, 3'b000};

    always_comb begin
        load_ext = data_q;
        case (size_q)
            2'b00:   load_ext = {{24{!uns_q && load_shift[7]}}, load_shift[7:0]};
            2'b01:   load_ext = {{16{!uns_q && load_shift[15]}}, load_shift[15:0]};
            default: load_ext = data_q;
        endcase
    end

    // Response flops load while in RESP, so the pulse follows the RESP cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= (state_q == StResp);
            resp_err_q   <= (state_q == StResp) && err_q;
            resp_rdata_q <= ((state_q == StResp) && rd_q && !err_q) ? load_ext : '0;
        end
    end

    assign bus_io.req_ready  = (state_q == StIdle);
    assign bus_io.resp_valid = resp_valid_q;
    assign bus_io.resp_err   = resp_err_q;
    assign bus_io.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: three instances with
// WAIT_STATES = 0, 1 and 7 share clock and reset; one is selected at a time.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  sel = 2'd1;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  size = 2'd2;
    logic        uns = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [32:0] sb_q[$];

    always #5 clk = ~clk;

    data_mem_responder_if bus0 ();
    data_mem_responder_if bus1 ();
    data_mem_responder_if bus7 ();

    assign bus0.req_addr = addr;  assign bus1.req_addr = addr;  assign bus7.req_addr = addr;
    assign bus0.req_wdata = wdata; assign bus1.req_wdata = wdata; assign bus7.req_wdata = wdata;
    assign bus0.req_size = size;  assign bus1.req_size = size;  assign bus7.req_size = size;
    assign bus0.req_unsigned = uns; assign bus1.req_unsigned = uns; assign bus7.req_unsigned = uns;
    assign bus0.req_rd = rd && (sel == 2'd0);
    assign bus1.req_rd = rd && (sel == 2'd1);
    assign bus7.req_rd = rd && (sel == 2'd2);
    assign bus0.req_wr = wr && (sel == 2'd0);
    assign bus1.req_wr = wr && (sel == 2'd1);
    assign bus7.req_wr = wr && (sel == 2'd2);

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst), .bus_io(bus0.slave));
    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus_io(bus1.slave));
    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(7)) u_dut7 (
        .clk(clk), .rst(rst), .bus_io(bus7.slave));

    logic        cur_ready, cur_valid, cur_err;
    logic [31:0] cur_rdata;

    always_comb begin
        cur_ready = bus1.req_ready;
        cur_valid = bus1.resp_valid;
        cur_err   = bus1.resp_err;
        cur_rdata = bus1.resp_rdata;
        case (sel)
            2'd0: begin
                cur_ready = bus0.req_ready;
                cur_valid = bus0.resp_valid;
                cur_err   = bus0.resp_err;
                cur_rdata = bus0.resp_rdata;
            end
            2'd2: begin
                cur_ready = bus7.req_ready;
                cur_valid = bus7.resp_valid;
                cur_err   = bus7.resp_err;
                cur_rdata = bus7.resp_rdata;
            end
            default: ;
        endcase
    end

    function automatic int ws_of(input logic [1:0] s);
        case (s)
            2'd0:    return 0;
            2'd1:    return 1;
            default: return 7;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // One request: wait for ready, push expectation, follow it to its response.
    task automatic xact(input logic [1:0] s, input logic r, input logic w, input logic [1:0] sz,
                        input logic u, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_d, input logic exp_e, input bit drift);
        int k;
        bit got;
        int ws;
        logic [32:0] exp;
        ws = ws_of(s);
        @(negedge clk);
        sel = s; addr = a; wdata = wd; size = sz; uns = u; rd = r; wr = w;
        k = 0;
        while (!cur_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!cur_ready) begin
            check_eq("ready_timeout", 64'(cur_ready), 64'd1);
            rd = 1'b0; wr = 1'b0;
            return;
        end
        sb_q.push_back({exp_e, exp_d});
        @(posedge clk);
        #1;
        rd = 1'b0; wr = 1'b0;
        if (drift) begin
            addr  = a ^ 32'h4;
            wdata = ~wd;
            uns   = ~u;
        end
        k = 0;
        got = 0;
        while (!got && k < 20) begin
            @(negedge clk);
            k++;
            if (cur_valid) begin
                got = 1;
                exp = sb_q.pop_front();
                check_eq("rdata", 64'(cur_rdata), 64'(exp[31:0]));
                check_eq("err", 64'(cur_err), 64'(exp[32]));
                check_eq("latency", 64'(k), 64'(2 + ws));
            end else begin
                if (k < 2 + ws) check_eq("ready_low", 64'(cur_ready), 64'd0);
                check_eq("idle_out", {31'd0, cur_err, cur_rdata}, 64'd0);
            end
        end
        if (!got) begin
            check_eq("resp_timeout", 64'(got), 64'd1);
            void'(sb_q.pop_front());
        end
    endtask

    // Hold a load asserted for `win` cycles and count acceptances/responses.
    task automatic thru(input logic [1:0] s, input int win, input int exp_acc);
        int n_acc;
        int n_resp;
        n_acc = 0;
        n_resp = 0;
        @(negedge clk);
        sel = s; addr = 32'h10; size = 2'd2; uns = 1'b0; rd = 1'b1; wr = 1'b0;
        for (int i = 0; i < win; i++) begin
            if (cur_ready) n_acc++;
            if (cur_valid) n_resp++;
            @(negedge clk);
        end
        rd = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (cur_valid) n_resp++;
            @(negedge clk);
        end
        check_eq("thru_acc", 64'(n_acc), 64'(exp_acc));
        check_eq("thru_resp", 64'(n_resp), 64'(exp_acc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        // Reset values
        repeat (2) @(negedge clk);
        check_eq("rst_ready", 64'(bus1.req_ready), 64'd1);
        check_eq("rst_valid", 64'(bus1.resp_valid), 64'd0);
        check_eq("rst_rdata", 64'(bus1.resp_rdata), 64'd0);
        check_eq("rst_err", 64'(bus1.resp_err), 64'd0);
        rst = 1'b0;

        // Word store then load
        xact(2'd1, 0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
        xact(2'd1, 1, 0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);

        // Byte and halfword lanes
        xact(2'd1, 0, 1, 2'd2, 0, 32'h20, 32'h11223344, 32'h0, 0, 0);
        xact(2'd1, 0, 1, 2'd0, 0, 32'h22, 32'h123456AA, 32'h0, 0, 0);
        xact(2'd1, 0, 1, 2'd1, 0, 32'h20, 32'hFFFF8001, 32'h0, 0, 0);
        xact(2'd1, 1, 0, 2'd2, 0, 32'h20, 32'h0, 32'h11AA8001, 0, 0);
        xact(2'd1, 1, 0, 2'd0, 0, 32'h22, 32'h0, 32'hFFFFFFAA, 0, 0);
        xact(2'd1, 1, 0, 2'd0, 1, 32'h22, 32'h0, 32'h000000AA, 0, 0);
        xact(2'd1, 1, 0, 2'd1, 0, 32'h20, 32'h0, 32'hFFFF8001, 0, 0);
        xact(2'd1, 1, 0, 2'd1, 1, 32'h22, 32'h0, 32'h000011AA, 0, 0);
        xact(2'd1, 1, 0, 2'd0, 0, 32'h23, 32'h0, 32'h00000011, 0, 0);
        xact(2'd1, 1, 0, 2'd0, 1, 32'h20, 32'h0, 32'h00000001, 0, 0);
        xact(2'd1, 1, 0, 2'd2, 1, 32'h20, 32'h0, 32'h11AA8001, 0, 0);

        // Errors, each followed where useful by a check that memory is untouched
        xact(2'd1, 1, 0, 2'd2, 0, 32'h21, 32'h0, 32'h0, 1, 0);
        xact(2'd1, 0, 1, 2'd1, 0, 32'h23, 32'h5555, 32'h0, 1, 0);
        xact(2'd1, 1, 0, 2'd2, 0, 32'h20, 32'h0, 32'h11AA8001, 0, 0);
        xact(2'd1, 1, 1, 2'd2, 0, 32'h20, 32'h0BADF00D, 32'h0, 1, 0);
        xact(2'd1, 1, 0, 2'd2, 0, 32'h20, 32'h0, 32'h11AA8001, 0, 0);
        xact(2'd1, 0, 1, 2'd3, 0, 32'h20, 32'h0BADF00D, 32'h0, 1, 0);
        xact(2'd1, 1, 0, 2'd2, 0, 32'h1000, 32'h0, 32'h0, 1, 0);
        xact(2'd1, 0, 1, 2'd2, 0, 32'hFFFFFFFC, 32'h0BADF00D, 32'h0, 1, 0);
        xact(2'd1, 0, 1, 2'd2, 0, 32'hFFC, 32'hA5A5C3C3, 32'h0, 0, 0);
        xact(2'd1, 1, 0, 2'd2, 0, 32'hFFC, 32'h0, 32'hA5A5C3C3, 0, 0);
        xact(2'd1, 1, 0, 2'd1, 0, 32'hFFE, 32'h0, 32'hFFFFA5A5, 0, 0);

        // Request drift after acceptance
        xact(2'd1, 0, 1, 2'd2, 0, 32'h44, 32'h01020304, 32'h0, 0, 0);
        xact(2'd1, 0, 1, 2'd2, 0, 32'h40, 32'hCAFEF00D, 32'h0, 0, 1);
        xact(2'd1, 1, 0, 2'd0, 0, 32'h43, 32'h0, 32'hFFFFFFCA, 0, 1);
        xact(2'd1, 1, 0, 2'd2, 0, 32'h40, 32'h0, 32'hCAFEF00D, 0, 0);
        xact(2'd1, 1, 0, 2'd2, 0, 32'h44, 32'h0, 32'h01020304, 0, 0);

        // WAIT_STATES = 0 and 7: latency and held-request throughput
        xact(2'd0, 0, 1, 2'd2, 0, 32'h10, 32'h600DCAFE, 32'h0, 0, 0);
        xact(2'd0, 1, 0, 2'd2, 0, 32'h10, 32'h0, 32'h600DCAFE, 0, 0);
        xact(2'd2, 0, 1, 2'd2, 0, 32'h10, 32'h7777ABCD, 32'h0, 0, 0);
        xact(2'd2, 1, 0, 2'd1, 0, 32'h10, 32'h0, 32'hFFFFABCD, 0, 0);
        thru(2'd0, 20, 10);
        thru(2'd2, 36, 4);

        // Reset during WAIT of a load
        xact(2'd1, 0, 1, 2'd2, 0, 32'h30, 32'h5A5AA5A5, 32'h0, 0, 0);
        @(negedge clk);
        sel = 2'd1; addr = 32'h30; size = 2'd2; uns = 1'b0; rd = 1'b1; wr = 1'b0;
        @(posedge clk);
        #1;
        rd = 1'b0;
        check_eq("wait_ready", 64'(cur_ready), 64'd0);
        #1;
        rst = 1'b1;
        #1;
        check_eq("midrst_ready", 64'(cur_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (cur_valid) nv++;
        end
        check_eq("midrst_no_resp", 64'(nv), 64'd0);
        xact(2'd1, 1, 0, 2'd2, 0, 32'h30, 32'h0, 32'h5A5AA5A5, 0, 0);

        check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
